// File: rtl/poly_reduce_seq_if.sv
// Control handshake and polynomial RAM port of poly_reduce_seq.
// master: the sequencer side; slave: key-gen controller plus RAM side.
interface poly_reduce_seq_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 6
);
    localparam int unsigned DATA_W = 32 * LANES;

    logic              start;
    logic              pause;
    logic              busy;
    logic              done;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  start, pause, mem_rdata,
        output busy, done, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata
    );

    modport slave (
        output start, pause, mem_rdata,
        input  busy, done, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/poly_reduce_seq.sv
// In-place Dilithium reduce32 over one 256-coefficient polynomial, LANES coefficients per RAM word.
// Optional feature: define POLY_REDUCE_SEQ_CADDQ_EN to add Q to negative results (output in [0, Q-1]).
module poly_reduce_seq #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned WORDS  = 256 / LANES,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    poly_reduce_seq_if.master      bus
);
    localparam int unsigned DATA_W = 32 * LANES;
    localparam logic signed [31:0] Q = 32'sd8380417;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              ren_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] red_c;

    // Single-lane reduce32, optionally followed by the conditional add of Q.
    function automatic logic [31:0] reduce32(input logic signed [31:0] a);
        logic signed [31:0] t;
        logic signed [31:0] r;
        t = (a + 32'sd4194304) >>> 23;
        r = a - t * Q;
`ifdef POLY_REDUCE_SEQ_CADDQ_EN
        if (r < 0) r = r + Q;
`endif
        return r;
    endfunction

    always_comb begin
        red_c = '0;
        for (int i = 0; i < LANES; i++)
            red_c[32*i +: 32] = reduce32(bus.mem_rdata[32*i +: 32]);
    end

    // Next-state and registered-output decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ren_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                busy_nxt = 1'b1;
                if (!bus.pause) begin
                    ren_nxt = 1'b1;
                    cnt_nxt = cnt + ADDR_W'(1);
                    if (cnt == LAST_ADDR) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Issued read or data-return stage still occupied means one more write to come.
                if (bus.mem_ren || v1) begin
                    busy_nxt = 1'b1;
                end else begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            v1            <= 1'b0;
            a1            <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_ren   <= 1'b0;
            bus.mem_raddr <= '0;
            bus.mem_wen   <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bus.busy    <= busy_nxt;
            bus.done    <= done_nxt;
            bus.mem_ren <= ren_nxt;
            if (ren_nxt) bus.mem_raddr <= cnt;
            // Read-return stage, then write-back stage.
            v1          <= bus.mem_ren;
            a1          <= bus.mem_raddr;
            bus.mem_wen <= v1;
            if (v1) begin
                bus.mem_waddr <= a1;
                bus.mem_wdata <= red_c;
            end
        end
    end
endmodule
